data_mem_sync: RTL and testbench
================================

# data_mem_sync

Parametrised synchronous data memory for the single-cycle datapath's load/store path. It supersedes the fixed 256x16 data memory with configurable word width, depth and per-byte write enables. It also adds a registered read with a valid strobe, out-of-range detection, and a hardware clear sequence that zeroes every word after reset. The block sits between the ALU result/`RD2` bus (address/store data) and the write-back mux (load data).

## Interface

Parameters:
- `DATA_W`, 16, word width in bits; must be a multiple of 8.
- `ADDR_W`, 8, address width in bits; word addressed.
- `DEPTH`, 256, number of words; 2 ≤ `DEPTH` ≤ 2^`ADDR_W`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `re`  in  1  read request.
- `we`  in  1  write request.
- `addr`  in  `ADDR_W`  word address for read and write.
- `wd`  in  `DATA_W`  write data.
- `be`  in  `DATA_W/8`  byte enables; bit i gates `wd[8i+7:8i]`.
- `rd`  out  `DATA_W`  registered read data.
- `rd_valid`  out  1  one-cycle strobe: `rd` updated by a read this cycle.
- `busy`  out  1  clear sequence in progress; requests ignored.
- `addr_err`  out  1  one-cycle strobe: previous accepted request had `addr` ≥ `DEPTH`.

## Operation

- FSM, two states:
  - CLEAR: entered on any edge with `rst`=1; the clear counter is set to 0.
  - IDLE: normal operation.
- CLEAR behaviour:
  - Each edge with `rst`=0 writes all-zero to `mem[cnt]` and increments `cnt`.
  - On the edge that writes `mem[DEPTH-1]`, the FSM moves to IDLE.
  - `busy` = (state == CLEAR).
  - `re`/`we` are ignored while `busy`=1: no write, no `rd_valid`, no `addr_err`.
- IDLE, request accepted when `re` or `we` is high:
  - Write: for each i with `be[i]`=1, `mem[addr]` byte i ← `wd` byte i; bytes with `be[i]`=0 are unchanged. `we` with `be`=0 is a legal no-op write.
  - Read: `rd` ← `mem[addr]` on the same edge; `rd_valid`=1 for the following cycle.
  - `re` and `we` together: both performed. `rd` returns the pre-write contents (read-first).
  - Out of range (`addr` ≥ `DEPTH`): the write is suppressed, a read loads `rd` ← 0 with `rd_valid`=1, and `addr_err`=1 for one cycle. Out of range is impossible when `DEPTH` = 2^`ADDR_W`.
- `rd` holds its last value when no read is accepted. `rd_valid` and `addr_err` return to 0 the next cycle.
- Reset mid-clear or mid-operation: the FSM returns to CLEAR, `cnt` restarts at 0, and the full clear repeats.

## Timing

- Reset values (the cycle after an edge with `rst`=1): `rd`=0, `rd_valid`=0, `addr_err`=0, `busy`=1.
- `busy` stays 1 for exactly `DEPTH` cycles after the first edge with `rst`=0. It falls after the `DEPTH`-th such edge.
- The first request can be accepted on the edge following `busy` falling.
- Read latency is 1 cycle: request at edge N, then `rd`/`rd_valid` valid between edges N and N+1.
- Write latency is 1 cycle: a write at edge N is visible to a read accepted at edge N+1.
- Back-to-back reads every cycle are supported; `rd_valid` stays high continuously.
- `addr_err` is aligned with `rd_valid` (same cycle) for reads. For writes it is asserted in the cycle after the edge.

## Test plan

- Reset/clear, `DEPTH`=256: hold `rst` 3 cycles, release. Require `busy`=1 for exactly 256 cycles, then 0. Then read addresses 0, 128, 255; each gives `rd`=0x0000 with a `rd_valid` pulse.
- Byte enables, `DATA_W`=16: write 0xBEEF to address 5 with `be`=2'b11, then write 0x1234 with `be`=2'b01, then read address 5. Require `rd`=0xBE34.
- Read-during-write: with `mem[7]`=0x00AA, assert `re`=`we`=1, `addr`=7, `wd`=0x5555, `be`=11. Require `rd`=0x00AA. A read the next cycle gives 0x5555.
- Out of range, `DEPTH`=200 and `ADDR_W`=8: write 0xFFFF to address 210, then read address 210. Require `addr_err` pulses after each request and `rd`=0. `mem[210 mod 200]`=`mem[10]` is unchanged (still 0).
- Requests during clear and mid-clear reset: issue `we` to address 3 with 0x1111 while `busy`=1. Assert `rst` at clear count 100 and release. Require `busy` lasts 256 more cycles, then a read of address 3 gives 0x0000 and no `rd_valid` occurred while `busy`=1.

Source files
------------

// File: rtl/data_mem_sync.sv
// rtl/data_mem_sync.sv - parametrised byte-enabled data memory with registered read and post-reset clear
module data_mem_sync #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  re,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wd,
    input  logic [DATA_W/8-1:0]   be,
    output logic [DATA_W-1:0]     rd,
    output logic                  rd_valid,
    output logic                  busy,
    output logic                  addr_err
);
    localparam int NB = DATA_W / 8;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;

    assign in_range = 32'(addr) < DEPTH;
    assign busy     = (state == ST_CLEAR);

    // Storage has no reset of its own; the clear walk zeroes it one word per cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_CLEAR) begin
                mem[cnt] <= '0;
            end else if (we && in_range) begin
                for (int i = 0; i < NB; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wd[8*i +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLEAR;
            cnt      <= '0;
            rd       <= '0;
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            addr_err <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (re || we) begin
                        addr_err <= !in_range;
                        // Read samples the array before this edge's write lands: read-first.
                        if (re) begin
                            rd       <= in_range ? mem[addr] : '0;
                            rd_valid <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_sync.sv
// tb/tb_data_mem_sync.sv - randomized and directed checks of data_mem_sync against a reference model
module tb_data_mem_sync;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        re = 1'b0, we = 1'b0;
    logic [7:0]  addr = '0;
    logic [15:0] wd = '0;
    logic [1:0]  be = '0;
    logic [15:0] rd0, rd1;
    logic        rv0, rv1, busy0, busy1, err0, err1;

    int errors = 0;
    int checks = 0;

    logic [15:0] mm [2][256];
    int          dep [2];
    int          rem [2];
    logic [15:0] e_rd [2];
    logic        e_rv [2];
    logic        e_err [2];

    always #5 clk = ~clk;

    data_mem_sync #(.DATA_W(16), .ADDR_W(8), .DEPTH(256)) dut0 (
        .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wd(wd), .be(be),
        .rd(rd0), .rd_valid(rv0), .busy(busy0), .addr_err(err0)
    );

    data_mem_sync #(.DATA_W(16), .ADDR_W(8), .DEPTH(200)) dut1 (
        .clk(clk), .rst(rst), .re(re), .we(we), .addr(addr), .wd(wd), .be(be),
        .rd(rd1), .rd_valid(rv1), .busy(busy1), .addr_err(err1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r_s, input bit r, input bit w, input int a,
                        input logic [15:0] d, input logic [1:0] b);
        bit oor;
        rst = r_s; re = r; we = w; addr = 8'(a); wd = d; be = b;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (r_s) begin
                rem[k] = dep[k];
                e_rd[k] = '0; e_rv[k] = 1'b0; e_err[k] = 1'b0;
                for (int j = 0; j < 256; j++) mm[k][j] = '0;
            end else if (rem[k] > 0) begin
                rem[k]--;
                e_rv[k] = 1'b0; e_err[k] = 1'b0;
            end else begin
                oor = (a >= dep[k]);
                e_rv[k]  = r;
                e_err[k] = (r || w) && oor;
                if (r) e_rd[k] = oor ? 16'h0000 : mm[k][a];
                if (w && !oor) begin
                    if (b[0]) mm[k][a][7:0]  = d[7:0];
                    if (b[1]) mm[k][a][15:8] = d[15:8];
                end
            end
        end
        #1;
        chk("rd0", 32'(rd0), 32'(e_rd[0]));
        chk("rd_valid0", 32'(rv0), 32'(e_rv[0]));
        chk("addr_err0", 32'(err0), 32'(e_err[0]));
        chk("busy0", 32'(busy0), 32'(rem[0] > 0));
        chk("rd1", 32'(rd1), 32'(e_rd[1]));
        chk("rd_valid1", 32'(rv1), 32'(e_rv[1]));
        chk("addr_err1", 32'(err1), 32'(e_err[1]));
        chk("busy1", 32'(busy1), 32'(rem[1] > 0));
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 0, 16'h0, 2'b00);
    endtask

    task automatic clear_len(output int n);
        n = 0;
        while (busy0 === 1'b1 && n < 400) begin
            n++;
            idle();
        end
    endtask

    int n;

    initial begin
        dep[0] = 256; dep[1] = 200;
        for (int k = 0; k < 2; k++) begin
            rem[k] = 0; e_rd[k] = '0; e_rv[k] = 1'b0; e_err[k] = 1'b0;
        end

        // reset held three cycles, then the full clear walk
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0, 16'h0, 2'b00);
        chk("reset_rd", 32'(rd0), 32'h0);
        chk("reset_busy", 32'(busy0), 32'h1);
        clear_len(n);
        chk("clear_len", 32'(n), 32'd256);

        foreach (dep[i]) begin end
        step(1'b0, 1'b1, 1'b0, 0,   16'h0, 2'b00);
        step(1'b0, 1'b1, 1'b0, 128, 16'h0, 2'b00);
        step(1'b0, 1'b1, 1'b0, 255, 16'h0, 2'b00);
        chk("read255_rd", 32'(rd0), 32'h0);
        chk("read255_valid", 32'(rv0), 32'h1);

        // byte enables
        step(1'b0, 1'b0, 1'b1, 5, 16'hBEEF, 2'b11);
        step(1'b0, 1'b0, 1'b1, 5, 16'h1234, 2'b01);
        step(1'b0, 1'b1, 1'b0, 5, 16'h0000, 2'b00);
        chk("byte_en", 32'(rd0), 32'hBE34);

        // read-during-write returns old contents
        step(1'b0, 1'b0, 1'b1, 7, 16'h00AA, 2'b11);
        step(1'b0, 1'b1, 1'b1, 7, 16'h5555, 2'b11);
        chk("rdw_old", 32'(rd0), 32'h00AA);
        step(1'b0, 1'b1, 1'b0, 7, 16'h0000, 2'b00);
        chk("rdw_new", 32'(rd0), 32'h5555);

        // out of range on the 200-deep instance
        step(1'b0, 1'b0, 1'b1, 210, 16'hFFFF, 2'b11);
        chk("oor_wr_err", 32'(err1), 32'h1);
        step(1'b0, 1'b1, 1'b0, 210, 16'h0000, 2'b00);
        chk("oor_rd_err", 32'(err1), 32'h1);
        chk("oor_rd_val", 32'(rd1), 32'h0);
        chk("oor_rd_valid", 32'(rv1), 32'h1);
        step(1'b0, 1'b1, 1'b0, 10, 16'h0000, 2'b00);
        chk("oor_alias", 32'(rd1), 32'h0);
        chk("oor_alias_err", 32'(err1), 32'h0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)), 16'($urandom), 2'($urandom_range(0, 3)));
        end

        // requests during clear, then reset mid-clear at count 100
        step(1'b1, 1'b0, 1'b0, 0, 16'h0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 3, 16'h1111, 2'b11);
        for (int i = 0; i < 99; i++) step(1'b0, 1'b1, 1'b1, 3, 16'h1111, 2'b11);
        step(1'b1, 1'b0, 1'b0, 0, 16'h0, 2'b00);
        clear_len(n);
        chk("midclr_len", 32'(n), 32'd256);
        step(1'b0, 1'b1, 1'b0, 3, 16'h0000, 2'b00);
        chk("midclr_rd3", 32'(rd0), 32'h0);
        chk("midclr_valid", 32'(rv0), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
